// File: rtl/uart_mem_loader_if.sv
// Loader-side bus bundle: RX FIFO pop port, TX FIFO push port and instruction-memory write port.
// Handshake: rx_empty=0 means r_data is valid (show-ahead); the byte is taken on the rising edge
// where rd_uart=1, and rd_uart is never 1 while rx_empty=1. A byte is pushed on the edge where
// wr_uart=1, and wr_uart is never 1 while tx_full=1. mem_we is a single-cycle write strobe.
interface uart_mem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_empty;
    logic [7:0]        r_data;
    logic              rd_uart;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, wr_uart, w_data, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, wr_uart, w_data, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_mem_loader.sv
// UART boot loader: framed RX bytes -> little-endian 32-bit words into instruction memory, status byte to TX.
// Define UART_LDR_CSUM_EN to add a trailing XOR checksum byte and an 'E' status on mismatch.
module uart_mem_loader #(
    parameter int         ADDR_W = 10,
    parameter logic [7:0] HDR    = 8'hA5,
    parameter int         TO_CYC = 500000,
    parameter int         TO_W   = 19
) (
    input  logic              clk,
    input  logic              reset,
    uart_mem_loader_if.master bus,
    output logic              cpu_hold,
    output logic              done,
    output logic [2:0]        dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
`ifdef UART_LDR_CSUM_EN
        CSUM = 3'd4,
`endif
        ACK  = 3'd5
    } state_t;

`ifdef UART_LDR_CSUM_EN
    localparam state_t POST_DATA = CSUM;
`else
    localparam state_t POST_DATA = ACK;
`endif
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    state_t            state, state_n;
    logic              run;
    logic              pop;
    logic              in_frame;
    logic              timeout;
    logic              last_word;
    logic [TO_W-1:0]   timer;
    logic [15:0]       len;
    logic [15:0]       word_cnt;
    logic [1:0]        byte_idx;
    logic [23:0]       word_lo;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        status;
`ifdef UART_LDR_CSUM_EN
    logic [7:0]        csum;
    logic              csum_ok;

    assign status = csum_ok ? 8'h4B : 8'h45;
`else
    assign status = 8'h4B;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        bus.wr_uart = 1'b0;
        done        = 1'b0;
        in_frame    = (state != IDLE) && (state != ACK);
        // run keeps the pop strobe low during and just after reset, whatever the FIFO shows
        pop         = run && !bus.rx_empty && (state != ACK);
        timeout     = in_frame && !pop && (timer == TO_LAST);
        last_word   = (byte_idx == 2'd3) && (word_cnt == len - 16'd1);
        case (state)
            IDLE: if (pop && bus.r_data == HDR) state_n = LEN0;
            LEN0: if (pop) state_n = LEN1;
            LEN1: if (pop) state_n = ({bus.r_data, len[7:0]} == 16'd0) ? POST_DATA : DATA;
            DATA: if (pop && last_word) state_n = POST_DATA;
`ifdef UART_LDR_CSUM_EN
            CSUM: if (pop) state_n = ACK;
`endif
            ACK: begin
                if (!bus.tx_full) begin
                    bus.wr_uart = 1'b1;
                    done        = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = IDLE;
    end

    assign bus.rd_uart = pop;
    assign bus.w_data  = (state == ACK) ? status : 8'h00;
    assign cpu_hold    = (state != IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run           <= 1'b0;
            timer         <= '0;
            len           <= '0;
            word_cnt      <= '0;
            byte_idx      <= '0;
            word_lo       <= '0;
            word_addr     <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
`ifdef UART_LDR_CSUM_EN
            csum          <= '0;
            csum_ok       <= 1'b0;
`endif
        end else begin
            run        <= 1'b1;
            bus.mem_we <= 1'b0;
            if (!in_frame || pop || timeout) timer <= '0;
            else                             timer <= timer + TO_W'(1);
            if (pop) begin
                case (state)
                    IDLE: begin
                        // A new header restarts addressing; any partial word from a timed-out frame is dropped
                        if (bus.r_data == HDR) begin
                            word_cnt  <= '0;
                            byte_idx  <= '0;
                            word_addr <= '0;
`ifdef UART_LDR_CSUM_EN
                            csum      <= '0;
`endif
                        end
                    end
                    LEN0: len <= {8'h00, bus.r_data};
                    LEN1: len[15:8] <= bus.r_data;
                    DATA: begin
                        word_lo  <= {bus.r_data, word_lo[23:8]};
                        byte_idx <= byte_idx + 2'd1;
`ifdef UART_LDR_CSUM_EN
                        csum     <= csum ^ bus.r_data;
`endif
                        if (byte_idx == 2'd3) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= word_addr;
                            bus.mem_wdata <= {bus.r_data, word_lo};
                            word_addr     <= word_addr + ADDR_W'(1);
                            word_cnt      <= word_cnt + 16'd1;
                        end
                    end
`ifdef UART_LDR_CSUM_EN
                    CSUM: csum_ok <= (bus.r_data == csum);
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule
